// File: rtl/wb_mem.sv
// wb_mem: Wishbone B4 pipelined word memory with a LATENCY-deep {valid, err} response pipeline.
// Build option: define WB_MEM_WRITE_EN for a byte-writable RAM; otherwise the array is a preloaded ROM.
module wb_mem #(
  parameter int SIZE       = 'h1000,
  parameter int ADDR_WIDTH = $clog2(SIZE),
  parameter int DATA_WIDTH = 16,
  parameter int LATENCY    = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    stall_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic                  acc;
  logic                  in_range;
  logic                  req_err;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] mem [SIZE];

  logic [DATA_WIDTH-1:0] dat_p0;
  logic                  vld_p0;
  logic                  err_p0;

  logic                  vld_out;
  logic                  err_out;
  logic [DATA_WIDTH-1:0] dat_out;

  assign stall_o  = 1'b0;
  assign acc      = cyc_i & stb_i & ~stall_o;
  assign in_range = {1'b0, adr_i} < (ADDR_WIDTH + 1)'(SIZE);
  assign rd_hit   = acc & in_range & ~we_i;

`ifdef WB_MEM_WRITE_EN
  assign req_err = ~in_range;

  always_ff @(posedge clock) begin
    if (acc && in_range && we_i) begin
      for (int k = 0; k < NB; k++) begin
        if (sel_i[k]) mem[adr_i][k*8 +: 8] <= dat_i[k*8 +: 8];
      end
    end
  end
`else
  // Fixed ROM image: each byte lane is a simple hash of the word address.
  function automatic logic [DATA_WIDTH-1:0] rom_init(input int unsigned a);
    logic [DATA_WIDTH-1:0] w;
    for (int k = 0; k < NB; k++) begin
      w[k*8 +: 8] = 8'(a * 7 + (a >> 8) * 13 + k * 61) ^ 8'hA5;
    end
    return w;
  endfunction

  assign req_err = ~in_range | we_i;

  for (genvar i = 0; i < SIZE; i++) begin : g_rom
    assign mem[i] = rom_init(i);
  end

  logic unused_wr;
  assign unused_wr = ^{dat_i, sel_i};
`endif

  // Stage p0: array read (read-first) and request status captured at the accept edge.
  always_ff @(posedge clock) begin
    dat_p0 <= rd_hit ? mem[adr_i] : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;
      err_p0 <= 1'b0;
    end else begin
      vld_p0 <= acc;
      err_p0 <= acc & req_err;
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic                  vld_p1;
    logic                  err_p1;
    logic [DATA_WIDTH-1:0] dat_p1;

    // Stage p1: output register; dropping cyc_i kills the request still in p0.
    always_ff @(posedge clock) begin
      dat_p1 <= dat_p0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        vld_p1 <= 1'b0;
        err_p1 <= 1'b0;
      end else begin
        vld_p1 <= vld_p0 & cyc_i;
        err_p1 <= err_p0 & cyc_i;
      end
    end

    assign vld_out = vld_p1;
    assign err_out = err_p1;
    assign dat_out = dat_p1;
  end else begin : g_lat1
    assign vld_out = vld_p0;
    assign err_out = err_p0;
    assign dat_out = dat_p0;
  end

  assign ack_o = vld_out & ~err_out;
  assign err_o = vld_out & err_out;
  assign dat_o = ack_o ? dat_out : '0;

endmodule

// File: tb/tb_wb_mem.sv
// Bench for wb_mem: a LATENCY=1/SIZE='h1000 instance and a LATENCY=2/SIZE=3000 instance share stimulus.
// A queue-based reference model predicts every termination; build mode follows WB_MEM_WRITE_EN.
`timescale 1ns/1ps
module tb_wb_mem;

  logic        clock;
  logic        reset_n;
  logic        cyc, stb, we;
  logic [11:0] adr;
  logic [15:0] dat;
  logic [1:0]  sel;

  logic [15:0] dat_a, dat_b;
  logic        ack_a, err_a, stall_a;
  logic        ack_b, err_b, stall_b;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  wb_mem #(.SIZE('h1000), .ADDR_WIDTH(12), .DATA_WIDTH(16), .LATENCY(1)) u_a (
    .clock(clock), .reset_n(reset_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .adr_i(adr), .dat_i(dat), .sel_i(sel),
    .dat_o(dat_a), .ack_o(ack_a), .err_o(err_a), .stall_o(stall_a)
  );

  wb_mem #(.SIZE(3000), .ADDR_WIDTH(12), .DATA_WIDTH(16), .LATENCY(2)) u_b (
    .clock(clock), .reset_n(reset_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .adr_i(adr), .dat_i(dat), .sel_i(sel),
    .dat_o(dat_b), .ack_o(ack_b), .err_o(err_b), .stall_o(stall_b)
  );

  // Reference model: pending terminations keyed by the edge after which they are visible.
  typedef struct {
    int          oe;
    bit          ack;
    bit          err;
    logic [15:0] dat;
  } term_t;

  typedef struct {
    bit          c;
    bit          s;
    bit          w;
    logic [11:0] a;
    logic [15:0] d;
    logic [1:0]  sl;
    bit          eack;
    bit          eerr;
    logic [15:0] edat;
  } vec_t;

  term_t       qa[$];
  term_t       qb[$];
  vec_t        tbl[$];
  logic [15:0] mem_a [4096];
  logic [15:0] mem_b [3000];
  int          edge_n;
  int          total;
  int          bad;

  function automatic logic [15:0] rom_ref(input int a);
    int base;
    logic [7:0] lo, hi;
    base = a * 7 + (a / 256) * 13;
    lo = 8'(base % 256) ^ 8'hA5;
    hi = 8'((base + 61) % 256) ^ 8'hA5;
    return {hi, lo};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic serve(input bit is_b, input bit w, input int a, input logic [15:0] d,
                       input logic [1:0] sl, input int oe, output term_t t);
    int          size;
    logic [15:0] cur;
    logic [15:0] merged;
    size  = is_b ? 3000 : 4096;
    t.oe  = oe;
    t.ack = 1'b0;
    t.err = 1'b0;
    t.dat = 16'h0;
    if (a >= size) begin
      t.err = 1'b1;
    end else begin
      cur    = is_b ? mem_b[a] : mem_a[a];
      merged = {sl[1] ? d[15:8] : cur[15:8], sl[0] ? d[7:0] : cur[7:0]};
      if (w) begin
`ifdef WB_MEM_WRITE_EN
        if (is_b) mem_b[a] = merged;
        else      mem_a[a] = merged;
        t.ack = 1'b1;
`else
        t.err = 1'b1;
`endif
      end else begin
        t.ack = 1'b1;
        t.dat = cur;
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare both DUTs 1ns later.
  task automatic step(input bit c, input bit s, input bit w, input logic [11:0] a,
                      input logic [15:0] d, input logic [1:0] sl);
    term_t ta, tb2, ea, eb;
    cyc = c; stb = s; we = w; adr = a; dat = d; sel = sl;
    @(posedge clock);
    edge_n++;
    if (!reset_n) begin
      qa.delete();
      qb.delete();
    end else if (!c) begin
      while (qa.size() > 0 && qa[$].oe >= edge_n) void'(qa.pop_back());
      while (qb.size() > 0 && qb[$].oe >= edge_n) void'(qb.pop_back());
    end else if (s) begin
      serve(1'b0, w, int'(a), d, sl, edge_n, ta);
      qa.push_back(ta);
      serve(1'b1, w, int'(a), d, sl, edge_n + 1, tb2);
      qb.push_back(tb2);
    end
    #1;
    ea = '{oe: 0, ack: 1'b0, err: 1'b0, dat: 16'h0};
    eb = ea;
    if (qa.size() > 0 && qa[0].oe == edge_n) ea = qa.pop_front();
    if (qb.size() > 0 && qb[0].oe == edge_n) eb = qb.pop_front();
    chk("resp_a", 32'({stall_a, err_a, ack_a, dat_a}), 32'({1'b0, ea.err, ea.ack, ea.dat}));
    chk("resp_b", 32'({stall_b, err_b, ack_b, dat_b}), 32'({1'b0, eb.err, eb.ack, eb.dat}));
  endtask

  task automatic reset_pulse();
    #3 reset_n = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    chk("rst_async_a", 32'({err_a, ack_a, dat_a}), 32'h0);
    chk("rst_async_b", 32'({err_b, ack_b, dat_b}), 32'h0);
    step(1'b0, 1'b0, 1'b0, 12'd0, 16'h0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 12'd0, 16'h0, 2'b00);
    #3 reset_n = 1'b1;
  endtask

  task automatic add(input bit c, input bit s, input bit w, input logic [11:0] a,
                     input logic [15:0] d, input logic [1:0] sl,
                     input bit eack, input bit eerr, input logic [15:0] edat);
    vec_t v;
    v.c = c; v.s = s; v.w = w; v.a = a; v.d = d; v.sl = sl;
    v.eack = eack; v.eerr = eerr; v.edat = edat;
    tbl.push_back(v);
  endtask

  initial begin
    logic [15:0] exp_b2b [4];
    total   = 0;
    bad     = 0;
    edge_n  = 0;
    reset_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
    for (int i = 0; i < 4096; i++) mem_a[i] = rom_ref(i);
    for (int i = 0; i < 3000; i++) mem_b[i] = rom_ref(i);

    // Reset state before any clock edge.
    #1;
    chk("reset_a", 32'({stall_a, err_a, ack_a, dat_a}), 32'h0);
    chk("reset_b", 32'({stall_b, err_b, ack_b, dat_b}), 32'h0);
    step(1'b1, 1'b1, 1'b0, 12'd1, 16'h0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 12'd0, 16'h0, 2'b00);
    #3 reset_n = 1'b1;

`ifdef WB_MEM_WRITE_EN
    for (int i = 0; i < 4096; i++)
      step(1'b1, 1'b1, 1'b1, 12'(i), 16'(i * 40503), 2'b11);
    add(1, 1, 1, 12'd5, 16'hBEEF, 2'b11, 1, 0, 16'h0000);
    add(1, 1, 0, 12'd5, 16'h0000, 2'b00, 1, 0, 16'hBEEF);
    add(1, 1, 1, 12'd7, 16'hFFFF, 2'b11, 1, 0, 16'h0000);
    add(1, 1, 1, 12'd7, 16'h1234, 2'b01, 1, 0, 16'h0000);
    add(1, 1, 0, 12'd7, 16'h0000, 2'b00, 1, 0, 16'hFF34);
    add(1, 0, 0, 12'd7, 16'h0000, 2'b00, 0, 0, 16'h0000);
    add(0, 1, 0, 12'd5, 16'h0000, 2'b00, 0, 0, 16'h0000);
    add(1, 1, 1, 12'd5, 16'h0000, 2'b00, 1, 0, 16'h0000);
    add(1, 1, 0, 12'd5, 16'h0000, 2'b00, 1, 0, 16'hBEEF);
    add(1, 1, 1, 12'd7, 16'hAB00, 2'b10, 1, 0, 16'h0000);
    add(1, 1, 0, 12'd7, 16'h0000, 2'b00, 1, 0, 16'hAB34);
`else
    add(1, 1, 1, 12'd1, 16'h5555, 2'b11, 0, 1, 16'h0000);
    add(1, 1, 0, 12'd1, 16'h0000, 2'b00, 1, 0, rom_ref(1));
    add(1, 1, 0, 12'd5, 16'h0000, 2'b00, 1, 0, rom_ref(5));
    add(1, 0, 0, 12'd5, 16'h0000, 2'b00, 0, 0, 16'h0000);
    add(0, 1, 0, 12'd5, 16'h0000, 2'b00, 0, 0, 16'h0000);
    add(1, 1, 0, 12'd4095, 16'h0000, 2'b00, 1, 0, rom_ref(4095));
    add(1, 1, 1, 12'd2999, 16'hFFFF, 2'b11, 0, 1, 16'h0000);
    add(1, 1, 0, 12'd2999, 16'h0000, 2'b00, 1, 0, rom_ref(2999));
`endif
    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].sl);
      chk($sformatf("vec%0d", i), 32'({err_a, ack_a, dat_a}),
          32'({tbl[i].eerr, tbl[i].eack, tbl[i].edat}));
    end

    // Back-to-back reads on the LATENCY=2 instance.
    step(1'b1, 1'b0, 1'b0, 12'd0, 16'h0, 2'b00);
    step(1'b1, 1'b0, 1'b0, 12'd0, 16'h0, 2'b00);
    for (int i = 0; i < 4; i++) exp_b2b[i] = mem_b[i];
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i < 4, 1'b0, 12'(i), 16'h0, 2'b00);
      chk($sformatf("b2b_ack%0d", i), 32'(ack_b), 32'(i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) chk($sformatf("b2b_dat%0d", i), 32'(dat_b), 32'(exp_b2b[i-1]));
    end

    // Out-of-range read: 3000 is past the end of u_b but inside u_a.
    step(1'b1, 1'b1, 1'b0, 12'd3000, 16'h0, 2'b00);
    chk("oor_a_ack", 32'({err_a, ack_a}), 32'b01);
    step(1'b1, 1'b0, 1'b0, 12'd0, 16'h0, 2'b00);
    chk("oor_b_err", 32'({err_b, ack_b, dat_b}), 32'({1'b1, 1'b0, 16'h0}));

    // Dropping cyc_i flushes the LATENCY=2 request still in flight.
    step(1'b1, 1'b1, 1'b0, 12'd10, 16'h0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 12'd0, 16'h0, 2'b00);
    chk("flush_rd", 32'({err_b, ack_b}), 32'b00);
    step(1'b1, 1'b1, 1'b0, 12'd3001, 16'h0, 2'b00);
    step(1'b0, 1'b1, 1'b0, 12'd3001, 16'h0, 2'b00);
    chk("flush_err", 32'({err_b, ack_b}), 32'b00);

    // Reset in the middle of a burst: nothing terminates, memory survives.
    step(1'b1, 1'b1, 1'b1, 12'd20, 16'hC0DE, 2'b11);
    step(1'b1, 1'b1, 1'b0, 12'd20, 16'h0, 2'b00);
    step(1'b1, 1'b1, 1'b0, 12'd21, 16'h0, 2'b00);
    reset_pulse();
    step(1'b1, 1'b1, 1'b0, 12'd20, 16'h0, 2'b00);
    chk("post_rst_a", 32'({ack_a, dat_a}), 32'({1'b1, mem_a[20]}));
    step(1'b1, 1'b1, 1'b0, 12'd21, 16'h0, 2'b00);
    chk("post_rst_b", 32'({ack_b, dat_b}), 32'({1'b1, mem_b[20]}));
    step(1'b1, 1'b0, 1'b0, 12'd0, 16'h0, 2'b00);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int          r;
      logic [11:0] a;
      r = int'($urandom_range(0, 3));
      case (r)
        0:       a = 12'($urandom_range(0, 15));
        1:       a = 12'($urandom_range(2990, 3010));
        2:       a = 12'($urandom_range(0, 4095));
        default: a = 12'($urandom_range(0, 7));
      endcase
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           a, 16'($urandom), 2'($urandom_range(0, 3)));
      if (n == 1500) reset_pulse();
    end

    step(1'b0, 1'b0, 1'b0, 12'd0, 16'h0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 12'd0, 16'h0, 2'b00);
    chk("drained", 32'(qa.size() + qb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
